semafor_sequencer: RTL and testbench
====================================

Name: semafor_sequencer

Overview:
Parametrised N-approach traffic-light phase sequencer. It replaces a fixed four-approach FSM with a single engine that walks approaches 0..N_APPROACH-1: green, yellow, then all-red for each. An optional pedestrian phase (steady green, then flashing green, then clearance) runs after the last approach. A service mode flashes yellow on every approach. It sits under the intersection top level, driven by an already-debounced service pulse and a pedestrian request pulse.

Parameters:
N_APPROACH, 4, number of vehicle approaches (2..8)
CNT_W, 6, width of every seconds field and counter
DIV_FACTOR, 10000000, clk cycles per second (even, >=2)
YELLOW_SEC, 3, yellow duration in seconds
ALLRED_SEC, 2, all-red clearance duration, also the init duration
PED_GREEN_SEC, 12, pedestrian steady-green seconds
PED_FLASH_SEC, 6, pedestrian flashing-green seconds
PED_ALWAYS, 0, 1 = pedestrian phase every cycle; 0 = only on latched request

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
green_sec_i  in  N_APPROACH*CNT_W  per-approach green seconds; approach k in bits [k*CNT_W +: CNT_W]; sampled on GREEN entry
service_btn_i  in  1  single-cycle debounced pulse; toggles service mode
ped_req_i  in  1  single-cycle pedestrian request pulse
green_o  out  N_APPROACH  vehicle green, one bit per approach
yellow_o  out  N_APPROACH  vehicle yellow
red_o  out  N_APPROACH  vehicle red
ped_green_o  out  1  pedestrian green
ped_red_o  out  1  pedestrian red
phase_o  out  3  current phase encoding (phase_t)
approach_o  out  3  current approach index
sec_left_o  out  CNT_W  seconds remaining in current phase

Behaviour:
- Reset: phase INIT, approach 0, sec counter = ALLRED_SEC, prescaler 0, svc_pend = 0, ped_pend = 0. Outputs: red_o all 1, green_o/yellow_o 0, ped_red_o 1, ped_green_o 0. Reset mid-phase aborts immediately to these values.
- Outputs are decoded from registered state only. They change on the same edge as the phase.
- Prescaler counts 0..DIV_FACTOR-1 and is cleared on every phase transition.
  - tick = (prescaler == DIV_FACTOR-1) → sec counter decrements.
  - A phase of D seconds lasts exactly D*DIV_FACTOR cycles.
  - blink = 1 while prescaler < DIV_FACTOR/2.
- On phase entry, sec counter loads the duration. Green duration is green_sec_i field k; a value of 0 is clamped to 1. Transition occurs on the tick where the counter equals 1.
- Phases:
  - INIT: all red → GREEN, approach 0.
  - GREEN(k): green_o[k] = 1, all other vehicle red → YELLOW(k).
  - YELLOW(k): yellow_o[k] = 1 → ALLRED(k).
  - ALLRED(k): all red.
    - k < N-1 → GREEN(k+1).
    - k = N-1 and (ped_pend or PED_ALWAYS) → PED_GREEN.
    - Otherwise → GREEN(0).
  - PED_GREEN: vehicles red, ped_green_o 1; ped_pend cleared on entry → PED_FLASH.
  - PED_FLASH: ped_green_o = blink, ped_red_o 0 → PED_CLEAR.
  - PED_CLEAR: all red (ALLRED_SEC) → GREEN(0).
  - SERVICE: yellow_o = {N{blink}}, green_o and red_o 0, both pedestrian lights 0. No timeout; sec_left_o holds 0.
- ped_req_i: sets ped_pend in any phase except SERVICE, where it is ignored. A request during PED_GREEN/PED_FLASH stays pending for the next cycle.
- service_btn_i outside SERVICE sets svc_pend. Safe exit path while svc_pend = 1:
  - GREEN: leave at the next tick → YELLOW (full yellow).
  - YELLOW: completes, then → SERVICE.
  - ALLRED/INIT: → SERVICE at the next tick.
  - PED_GREEN: leave at the next tick → PED_FLASH (full) → PED_CLEAR (full) → SERVICE.
- service_btn_i in SERVICE: → INIT (full all-red), approach 0; svc_pend and ped_pend cleared. Re-pulses while svc_pend = 1 have no further effect.
- Same-cycle service and ped pulses: both latched. Service takes priority over the pedestrian phase at ALLRED(N-1).

Decomposition:
- Shared package semafor_pkg:
  - phase_t enum: INIT=0, GREEN=1, YELLOW=2, ALLRED=3, PED_GREEN=4, PED_FLASH=5, PED_CLEAR=6, SERVICE=7.
  - Default-duration constants.
- Sub-module semafor_sec_tick: prescaler with clear input; outputs tick and blink; parameter DIV_FACTOR.

Test Plan:
All scenarios use DIV_FACTOR=4, N_APPROACH=4, YELLOW_SEC=2, ALLRED_SEC=1, PED_GREEN_SEC=2, PED_FLASH_SEC=1.
1. Release reset, green_sec all 3 → INIT 4 cycles, GREEN0 12, YELLOW0 8, ALLRED0 4, then GREEN1; sec_left_o counts 3,2,1.
2. Green field k=2 set to 0 → GREEN2 lasts 4 cycles (clamp to 1).
3. Pulse ped_req_i during GREEN1 → after ALLRED3: PED_GREEN 8 cycles, PED_FLASH 4 cycles with ped_green_o 1,1,0,0, PED_CLEAR 4 cycles, GREEN0; ped_pend cleared.
4. Pulse service_btn_i at cycle 2 of GREEN0 → YELLOW0 starts at cycle 4, runs 8 cycles, then SERVICE with yellow_o = 4'b1111/4'b0000 alternating every 2 cycles.
5. Pulse service_btn_i in SERVICE → INIT 4 cycles, GREEN0; same-cycle ped_req_i ignored (no pedestrian phase next cycle).
6. Assert rst mid-PED_FLASH → outputs immediately all red, ped_red_o 1, phase_o INIT, asynchronously without a clk edge.

Source files
------------

// File: rtl/semafor_pkg.sv
// Shared types and default timing constants for the traffic-light phase sequencer.
package semafor_pkg;

  localparam int unsigned PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    INIT      = 3'd0,
    GREEN     = 3'd1,
    YELLOW    = 3'd2,
    ALLRED    = 3'd3,
    PED_GREEN = 3'd4,
    PED_FLASH = 3'd5,
    PED_CLEAR = 3'd6,
    SERVICE   = 3'd7
  } phase_t;

  localparam int unsigned DEF_N_APPROACH    = 4;
  localparam int unsigned DEF_CNT_W         = 6;
  localparam int unsigned DEF_DIV_FACTOR    = 10000000;
  localparam int unsigned DEF_YELLOW_SEC    = 3;
  localparam int unsigned DEF_ALLRED_SEC    = 2;
  localparam int unsigned DEF_PED_GREEN_SEC = 12;
  localparam int unsigned DEF_PED_FLASH_SEC = 6;

endpackage

// File: rtl/semafor_sec_tick.sv
// Seconds prescaler: wraps every DIV_FACTOR cycles, restartable from zero via clr_i.
module semafor_sec_tick
  import semafor_pkg::*;
#(
  parameter int unsigned DIV_FACTOR = DEF_DIV_FACTOR
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_c_o,
  output logic blink_c_o
);

  localparam int unsigned PW = (DIV_FACTOR > 2) ? $clog2(DIV_FACTOR) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV_FACTOR - 1);
  localparam logic [PW-1:0] HALF = PW'(DIV_FACTOR / 2);

  logic [PW-1:0] presc_q, presc_d;

  // Next prescaler value: restart on phase change or on wrap.
  always_comb begin
    presc_d = presc_q + PW'(1);
    if (clr_i || (presc_q == LAST)) presc_d = '0;
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end

  assign tick_c_o  = (presc_q == LAST);
  assign blink_c_o = (presc_q < HALF);

endmodule

// File: rtl/semafor_sequencer.sv
// N-approach traffic-light phase sequencer with optional pedestrian phase and service flash mode.
module semafor_sequencer
  import semafor_pkg::*;
#(
  parameter int unsigned N_APPROACH    = DEF_N_APPROACH,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned DIV_FACTOR    = DEF_DIV_FACTOR,
  parameter int unsigned YELLOW_SEC    = DEF_YELLOW_SEC,
  parameter int unsigned ALLRED_SEC    = DEF_ALLRED_SEC,
  parameter int unsigned PED_GREEN_SEC = DEF_PED_GREEN_SEC,
  parameter int unsigned PED_FLASH_SEC = DEF_PED_FLASH_SEC,
  parameter int unsigned PED_ALWAYS    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_APPROACH*CNT_W-1:0] green_sec_i,
  input  logic                        service_btn_i,
  input  logic                        ped_req_i,
  output logic [N_APPROACH-1:0]       green_o,
  output logic [N_APPROACH-1:0]       yellow_o,
  output logic [N_APPROACH-1:0]       red_o,
  output logic                        ped_green_o,
  output logic                        ped_red_o,
  output logic [PHASE_W-1:0]          phase_o,
  output logic [2:0]                  approach_o,
  output logic [CNT_W-1:0]            sec_left_o
);

  localparam int unsigned AW = 3;
  localparam logic [AW-1:0]    LAST_AP = AW'(N_APPROACH - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  phase_t             phase_q, phase_d;
  logic [AW-1:0]      ap_q, ap_d;
  logic [CNT_W-1:0]   sec_q, sec_d;
  logic               svc_pend_q, svc_pend_d;
  logic               ped_pend_q, ped_pend_d;
  logic               load_c;
  logic [CNT_W-1:0]   g_sel_c;
  logic               tick_c, blink_c;
  logic [N_APPROACH-1:0] ap_oh_c;

  semafor_sec_tick #(
    .DIV_FACTOR(DIV_FACTOR)
  ) u_sec_tick (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (load_c),
    .tick_c_o (tick_c),
    .blink_c_o(blink_c)
  );

  // Phase, approach, seconds counter and pending-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= INIT;
      ap_q       <= '0;
      sec_q      <= CNT_W'(ALLRED_SEC);
      svc_pend_q <= 1'b0;
      ped_pend_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      ap_q       <= ap_d;
      sec_q      <= sec_d;
      svc_pend_q <= svc_pend_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  // Next-state: phase walk, safe service exit, request latching and duration load.
  always_comb begin
    phase_d    = phase_q;
    ap_d       = ap_q;
    sec_d      = sec_q;
    svc_pend_d = svc_pend_q;
    ped_pend_d = ped_pend_q;
    load_c     = 1'b0;
    g_sel_c    = '0;

    if (phase_q != SERVICE) begin
      if (service_btn_i) svc_pend_d = 1'b1;
      if (ped_req_i)     ped_pend_d = 1'b1;
    end

    case (phase_q)
      INIT: begin
        if (tick_c && (svc_pend_q || (sec_q == ONE))) begin
          load_c  = 1'b1;
          ap_d    = '0;
          phase_d = svc_pend_q ? SERVICE : GREEN;
        end
      end
      GREEN: begin
        if (tick_c && (svc_pend_q || (sec_q == ONE))) begin
          load_c  = 1'b1;
          phase_d = YELLOW;
        end
      end
      YELLOW: begin
        if (tick_c && (sec_q == ONE)) begin
          load_c  = 1'b1;
          phase_d = svc_pend_q ? SERVICE : ALLRED;
        end
      end
      ALLRED: begin
        if (tick_c && (svc_pend_q || (sec_q == ONE))) begin
          load_c = 1'b1;
          if (svc_pend_q) begin
            phase_d = SERVICE;
          end else if (ap_q != LAST_AP) begin
            phase_d = GREEN;
            ap_d    = ap_q + AW'(1);
          end else if (ped_pend_q || (PED_ALWAYS != 0)) begin
            phase_d = PED_GREEN;
          end else begin
            phase_d = GREEN;
            ap_d    = '0;
          end
        end
      end
      PED_GREEN: begin
        if (tick_c && (svc_pend_q || (sec_q == ONE))) begin
          load_c  = 1'b1;
          phase_d = PED_FLASH;
        end
      end
      PED_FLASH: begin
        if (tick_c && (sec_q == ONE)) begin
          load_c  = 1'b1;
          phase_d = PED_CLEAR;
        end
      end
      PED_CLEAR: begin
        if (tick_c && (sec_q == ONE)) begin
          load_c  = 1'b1;
          ap_d    = '0;
          phase_d = svc_pend_q ? SERVICE : GREEN;
        end
      end
      SERVICE: begin
        if (service_btn_i) begin
          load_c     = 1'b1;
          phase_d    = INIT;
          ap_d       = '0;
          svc_pend_d = 1'b0;
          ped_pend_d = 1'b0;
        end
      end
      default: begin
        load_c  = 1'b1;
        phase_d = INIT;
        ap_d    = '0;
      end
    endcase

    // Green time of the approach being entered; zero is treated as one second.
    for (int unsigned k = 0; k < N_APPROACH; k++) begin
      if (ap_d == AW'(k)) g_sel_c = green_sec_i[k*CNT_W +: CNT_W];
    end

    if (load_c) begin
      case (phase_d)
        GREEN:     sec_d = (g_sel_c == '0) ? ONE : g_sel_c;
        YELLOW:    sec_d = CNT_W'(YELLOW_SEC);
        PED_GREEN: begin
          sec_d      = CNT_W'(PED_GREEN_SEC);
          ped_pend_d = ped_req_i;
        end
        PED_FLASH: sec_d = CNT_W'(PED_FLASH_SEC);
        SERVICE:   sec_d = '0;
        default:   sec_d = CNT_W'(ALLRED_SEC);
      endcase
    end else if (tick_c && (phase_q != SERVICE)) begin
      sec_d = sec_q - ONE;
    end
  end

  // Lamp decode from registered phase and approach.
  always_comb begin
    ap_oh_c     = N_APPROACH'(1) << ap_q;
    green_o     = '0;
    yellow_o    = '0;
    red_o       = '1;
    ped_green_o = 1'b0;
    ped_red_o   = 1'b1;
    case (phase_q)
      GREEN: begin
        green_o = ap_oh_c;
        red_o   = ~ap_oh_c;
      end
      YELLOW: begin
        yellow_o = ap_oh_c;
        red_o    = ~ap_oh_c;
      end
      PED_GREEN: begin
        ped_green_o = 1'b1;
        ped_red_o   = 1'b0;
      end
      PED_FLASH: begin
        ped_green_o = blink_c;
        ped_red_o   = 1'b0;
      end
      SERVICE: begin
        yellow_o  = {N_APPROACH{blink_c}};
        red_o     = '0;
        ped_red_o = 1'b0;
      end
      default: ;
    endcase
  end

  assign phase_o    = phase_q;
  assign approach_o = ap_q;
  assign sec_left_o = sec_q;

endmodule

// File: tb/tb_semafor_sequencer.sv
// Directed bench for the phase sequencer with short timing parameters.
module tb_semafor_sequencer;

  localparam int unsigned N   = 4;
  localparam int unsigned CW  = 6;
  localparam int          DIV = 4;

  localparam logic [2:0] P_INIT      = 3'd0;
  localparam logic [2:0] P_GREEN     = 3'd1;
  localparam logic [2:0] P_YELLOW    = 3'd2;
  localparam logic [2:0] P_ALLRED    = 3'd3;
  localparam logic [2:0] P_PED_GREEN = 3'd4;
  localparam logic [2:0] P_PED_FLASH = 3'd5;
  localparam logic [2:0] P_PED_CLEAR = 3'd6;
  localparam logic [2:0] P_SERVICE   = 3'd7;

  logic            clk;
  logic            rst;
  logic [N*CW-1:0] green_sec_i;
  logic            service_btn_i;
  logic            ped_req_i;
  logic [N-1:0]    green_o, yellow_o, red_o;
  logic            ped_green_o, ped_red_o;
  logic [2:0]      phase_o, approach_o;
  logic [CW-1:0]   sec_left_o;

  int n_chk = 0;
  int n_bad = 0;
  int gdur [4];

  semafor_sequencer #(
    .N_APPROACH   (N),
    .CNT_W        (CW),
    .DIV_FACTOR   (DIV),
    .YELLOW_SEC   (2),
    .ALLRED_SEC   (1),
    .PED_GREEN_SEC(2),
    .PED_FLASH_SEC(1),
    .PED_ALWAYS   (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .green_sec_i  (green_sec_i),
    .service_btn_i(service_btn_i),
    .ped_req_i    (ped_req_i),
    .green_o      (green_o),
    .yellow_o     (yellow_o),
    .red_o        (red_o),
    .ped_green_o  (ped_green_o),
    .ped_red_o    (ped_red_o),
    .phase_o      (phase_o),
    .approach_o   (approach_o),
    .sec_left_o   (sec_left_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected lamps packed as {green, yellow, red, ped_green, ped_red}.
  function automatic logic [13:0] exp_lights(input logic [2:0] ph, input int ap, input logic bl);
    logic [3:0] g, y, r, oh;
    logic       pg, pr;
    oh = 4'(1) << ap;
    g = 4'h0; y = 4'h0; r = 4'hF; pg = 1'b0; pr = 1'b1;
    case (ph)
      P_GREEN:     begin g = oh; r = ~oh; end
      P_YELLOW:    begin y = oh; r = ~oh; end
      P_PED_GREEN: begin pg = 1'b1; pr = 1'b0; end
      P_PED_FLASH: begin pg = bl; pr = 1'b0; end
      P_SERVICE:   begin y = {4{bl}}; r = 4'h0; pr = 1'b0; end
      default: ;
    endcase
    return {g, y, r, pg, pr};
  endfunction

  function automatic logic [13:0] lights();
    return {green_o, yellow_o, red_o, ped_green_o, ped_red_o};
  endfunction

  // Checks every cycle of a phase of dur seconds, starting at cycle skip.
  task automatic run_phase(input logic [2:0] ph, input int ap, input int dur, input int skip);
    for (int i = skip; i < dur * DIV; i++) begin
      chk($sformatf("ph%0d_ap%0d_c%0d_phase", ph, ap, i), 32'(phase_o), 32'(ph));
      if (ph <= P_ALLRED)
        chk($sformatf("ph%0d_ap%0d_c%0d_appr", ph, ap, i), 32'(approach_o), 32'(ap));
      chk($sformatf("ph%0d_ap%0d_c%0d_sec", ph, ap, i), 32'(sec_left_o), 32'(dur - i / DIV));
      chk($sformatf("ph%0d_ap%0d_c%0d_lamps", ph, ap, i), 32'(lights()),
          32'(exp_lights(ph, ap, (i % DIV) < DIV / 2)));
      step();
    end
  endtask

  task automatic run_cycle();
    for (int k = 0; k < 4; k++) begin
      run_phase(P_GREEN, k, gdur[k], 0);
      run_phase(P_YELLOW, k, 2, 0);
      run_phase(P_ALLRED, k, 1, 0);
    end
  endtask

  task automatic wait_phase(input logic [2:0] ph, input int limit);
    for (int n = 0; n < limit && phase_o != ph; n++) step();
    chk($sformatf("wait_ph%0d", ph), 32'(phase_o), 32'(ph));
  endtask

  initial begin
    rst           = 1'b1;
    service_btn_i = 1'b0;
    ped_req_i     = 1'b0;
    green_sec_i   = {6'd3, 6'd0, 6'd3, 6'd3};
    gdur          = '{3, 3, 1, 3};
    repeat (3) step();

    // Reset state
    chk("rst_phase", 32'(phase_o), 32'(P_INIT));
    chk("rst_appr", 32'(approach_o), 32'd0);
    chk("rst_sec", 32'(sec_left_o), 32'd1);
    chk("rst_lamps", 32'(lights()), 32'(exp_lights(P_INIT, 0, 1'b1)));
    rst = 1'b0;

    // Power-up walk, with a pedestrian request during GREEN1
    run_phase(P_INIT, 0, 1, 0);
    run_phase(P_GREEN, 0, 3, 0);
    run_phase(P_YELLOW, 0, 2, 0);
    run_phase(P_ALLRED, 0, 1, 0);
    ped_req_i = 1'b1;
    chk("g1_c0_phase", 32'(phase_o), 32'(P_GREEN));
    step();
    ped_req_i = 1'b0;
    run_phase(P_GREEN, 1, 3, 1);
    run_phase(P_YELLOW, 1, 2, 0);
    run_phase(P_ALLRED, 1, 1, 0);
    for (int k = 2; k < 4; k++) begin
      run_phase(P_GREEN, k, gdur[k], 0);
      run_phase(P_YELLOW, k, 2, 0);
      run_phase(P_ALLRED, k, 1, 0);
    end
    run_phase(P_PED_GREEN, 3, 2, 0);
    run_phase(P_PED_FLASH, 3, 1, 0);
    run_phase(P_PED_CLEAR, 3, 1, 0);

    // Request consumed: next cycle has no pedestrian phase
    run_cycle();
    chk("noped_phase", 32'(phase_o), 32'(P_GREEN));
    chk("noped_appr", 32'(approach_o), 32'd0);

    // Service request at GREEN0 cycle 2
    step();
    step();
    service_btn_i = 1'b1;
    step();
    service_btn_i = 1'b0;
    chk("svc_g0_c3_phase", 32'(phase_o), 32'(P_GREEN));
    step();
    run_phase(P_YELLOW, 0, 2, 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("svc_c%0d_phase", i), 32'(phase_o), 32'(P_SERVICE));
      chk($sformatf("svc_c%0d_sec", i), 32'(sec_left_o), 32'd0);
      chk($sformatf("svc_c%0d_lamps", i), 32'(lights()),
          32'(exp_lights(P_SERVICE, 0, (i % DIV) < DIV / 2)));
      step();
    end

    // Leave service; the simultaneous pedestrian pulse is ignored
    service_btn_i = 1'b1;
    ped_req_i     = 1'b1;
    step();
    service_btn_i = 1'b0;
    ped_req_i     = 1'b0;
    run_phase(P_INIT, 0, 1, 0);
    run_cycle();
    chk("svcexit_noped_phase", 32'(phase_o), 32'(P_GREEN));
    chk("svcexit_noped_appr", 32'(approach_o), 32'd0);

    // Asynchronous reset in the middle of PED_FLASH
    ped_req_i = 1'b1;
    step();
    ped_req_i = 1'b0;
    wait_phase(P_PED_FLASH, 300);
    step();
    chk("flash_c1_pedg", 32'(ped_green_o), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_phase", 32'(phase_o), 32'(P_INIT));
    chk("arst_appr", 32'(approach_o), 32'd0);
    chk("arst_sec", 32'(sec_left_o), 32'd1);
    chk("arst_lamps", 32'(lights()), 32'(exp_lights(P_INIT, 0, 1'b1)));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
